// File: rtl/beehive_mem_pkg.sv
// Shared memory-controller definitions: cache-line geometry, return-bus idle code, sequencer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package beehive_mem_pkg;

  localparam int LINE_WORDS    = 8;
  localparam int LINE_OFS_BITS = 3;

  // Destination code meaning "no data on the return bus this cycle".
  localparam logic [3:0] RD_DEST_NONE = 4'h0;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  // Word index within a line, wrapping modulo the line length.
  function automatic logic [LINE_OFS_BITS-1:0] line_word(
    input logic [LINE_OFS_BITS-1:0] start,
    input logic [LINE_OFS_BITS-1:0] idx
  );
    return start + idx;
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic first-word-fall-through FIFO; head word is visible on pop_dat whenever empty is low.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: full is derived from the registered occupancy; pushes while full are ignored.
module fifo #(
  parameter int width   = 8,
  parameter int logsize = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [width-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [width-1:0] pop_dat,
  output logic             empty,
  output logic             full
);

  localparam logic [logsize:0] DEPTH = {1'b1, {logsize{1'b0}}};

  logic [width-1:0]   store [2**logsize];
  logic [logsize-1:0] wr_ptr;
  logic [logsize-1:0] rd_ptr;
  logic [logsize:0]   occ;
  logic               do_push;
  logic               do_pop;

  assign full    = (occ == DEPTH);
  assign empty   = (occ == '0);
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_rdy & ~empty;
  assign pop_dat = store[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + logsize'(1);
      if (do_pop)  rd_ptr <= rd_ptr + logsize'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (logsize+1)'(1);
        2'b01:   occ <= occ - (logsize+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/rd_return_sequencer.sv
// Read-return stage: queues line-read requests, reads 8 words per line, drives RDreturn/RDdest (RD_CRITICAL_WORD_FIRST_EN selects wrapped critical-word-first order).
// Latency: accept at edge ending T -> pop T+1, mem_rd_en T+2..T+9, word k on RDreturn at T+4+k.
// Backpressure: req_ready = ~full of the 2^LOGDEPTH request FIFO; the return bus never stalls.
module rd_return_sequencer
  import beehive_mem_pkg::*;
#(
  parameter int MBITS    = 24,
  parameter int LOGDEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_dest,
  input  logic [MBITS-1:0] req_addr,
  output logic             mem_rd_en,
  output logic [MBITS-1:0] mem_rd_addr,
  input  logic [31:0]      mem_rd_data,
  output logic [31:0]      RDreturn,
  output logic [3:0]       RDdest,
  output logic             busy,
  output logic             err_dest_zero
);

  localparam int LINE_BITS = MBITS - LINE_OFS_BITS;
  localparam logic [LINE_OFS_BITS-1:0] LAST_WORD = LINE_OFS_BITS'(LINE_WORDS - 1);

  // Start-offset mask: all ones keeps the requested word offset, zero forces line order.
`ifdef RD_CRITICAL_WORD_FIRST_EN
  localparam logic [LINE_OFS_BITS-1:0] START_MASK = '1;
`else
  localparam logic [LINE_OFS_BITS-1:0] START_MASK = '0;
`endif

  typedef struct packed {
    logic [3:0]       dest;
    logic [MBITS-1:0] addr;
  } rd_req_t;

  rd_req_t                  push_req;
  rd_req_t                  head;
  logic [4+MBITS-1:0]       head_dat;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop;
  logic                     head_ok;
  logic                     last_word;

  rd_state_e                state;
  logic [LINE_BITS-1:0]     burst_line;
  logic [3:0]               burst_dest;
  logic [LINE_OFS_BITS-1:0] start_ofs;
  logic [LINE_OFS_BITS-1:0] word_cnt;

  logic                     ret_vld;
  logic [3:0]               ret_dest;

  assign push_req  = {req_dest, req_addr};
  assign req_ready = ~fifo_full;

  fifo #(
    .width  (4 + MBITS),
    .logsize(LOGDEPTH)
  ) u_req_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_vld(req_valid),
    .push_dat(push_req),
    .pop_rdy (pop),
    .pop_dat (head_dat),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign head      = head_dat;
  assign head_ok   = (head.dest != RD_DEST_NONE);
  assign last_word = (word_cnt == LAST_WORD);

  // The head is consumed when idle, or on the last word of a burst so the next line follows without a bubble.
  assign pop = ~fifo_empty & ((state == RD_IDLE) | ((state == RD_BURST) & last_word));

  // Burst sequencer: loads a line from the queue head, steps through its 8 words, discards dest-0 requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RD_IDLE;
      burst_line    <= '0;
      burst_dest    <= RD_DEST_NONE;
      start_ofs     <= '0;
      word_cnt      <= '0;
      err_dest_zero <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (pop) begin
            if (head_ok) begin
              burst_line <= head.addr[MBITS-1:LINE_OFS_BITS];
              burst_dest <= head.dest;
              start_ofs  <= head.addr[LINE_OFS_BITS-1:0] & START_MASK;
              word_cnt   <= '0;
              state      <= RD_BURST;
            end else begin
              err_dest_zero <= 1'b1;
            end
          end
        end
        RD_BURST: begin
          word_cnt <= word_cnt + LINE_OFS_BITS'(1);
          if (last_word) begin
            if (pop && head_ok) begin
              burst_line <= head.addr[MBITS-1:LINE_OFS_BITS];
              burst_dest <= head.dest;
              start_ofs  <= head.addr[LINE_OFS_BITS-1:0] & START_MASK;
              word_cnt   <= '0;
            end else begin
              state <= RD_IDLE;
              if (pop) err_dest_zero <= 1'b1;
            end
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  assign mem_rd_en   = (state == RD_BURST);
  assign mem_rd_addr = mem_rd_en ? {burst_line, line_word(start_ofs, word_cnt)} : '0;

  // Return pipeline: destination tracks the read through the memory cycle, then registers data onto the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ret_vld  <= 1'b0;
      ret_dest <= RD_DEST_NONE;
      RDreturn <= '0;
      RDdest   <= RD_DEST_NONE;
    end else begin
      ret_vld  <= mem_rd_en;
      ret_dest <= mem_rd_en ? burst_dest : RD_DEST_NONE;
      RDreturn <= ret_vld ? mem_rd_data : '0;
      RDdest   <= ret_vld ? ret_dest : RD_DEST_NONE;
    end
  end

  assign busy = (state == RD_BURST) | ~fifo_empty | ret_vld;

endmodule

// File: tb/tb_rd_return_sequencer.sv
// Directed bench for rd_return_sequencer with a line-return scoreboard.
// Latency: memory model returns addr as data one cycle after mem_rd_en.
// Backpressure: requests wait on req_ready; RD_CRITICAL_WORD_FIRST_EN changes expected word order.
module tb_rd_return_sequencer;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dest = 4'h0;
  logic [23:0] req_addr = 24'h0;
  logic        mem_rd_en;
  logic [23:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        busy;
  logic        err_dest_zero;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int words_seen = 0;
  int saw_stall = 0;
  int bad_line = 0;
  exp_t sb[$];

  // loop scratch for the directed sequence
  int t0;
  int n;
  int last_en;
  int busy_fall;
  int run;
  int max_run;
  int en_after_rst;

  rd_return_sequencer #(.MBITS(24), .LOGDEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dest     (req_dest),
    .req_addr     (req_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .RDreturn     (RDreturn),
    .RDdest       (RDdest),
    .busy         (busy),
    .err_dest_zero(err_dest_zero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // memory holds its own word address; poison when not strobed
  always @(posedge clock) mem_rd_data <= mem_rd_en ? {8'h00, mem_rd_addr} : 32'hdeadbeef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor on the return bus
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_rd_en && mem_rd_addr[23:3] == 21'(24'h000500 >> 3)) bad_line = 1;
      if (RDdest != 4'h0) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ret_dest", 32'(RDdest), 32'(e.dest));
          chk("ret_data", RDreturn, e.data);
          words_seen++;
        end
      end else begin
        chk("idle_data_zero", RDreturn, 32'h0);
      end
    end
  end

  // call just after a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [3:0] d, input logic [23:0] a);
    int guard;
    logic [2:0] st;
    guard = 0;
    req_valid = 1'b1;
    req_dest  = d;
    req_addr  = a;
    if (!req_ready) saw_stall = 1;
    while (!req_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    chk("send_ready_timeout", 32'(guard < 2000), 32'd1);
`ifdef RD_CRITICAL_WORD_FIRST_EN
    st = a[2:0];
`else
    st = 3'd0;
`endif
    if (d != 4'h0) begin
      for (int k = 0; k < 8; k++) begin
        logic [2:0] w;
        w = st + 3'(k);
        sb.push_back('{dest: d, data: {8'h00, a[23:3], w}});
      end
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((busy || RDdest != 4'h0 || sb.size() != 0) && g < 1000) begin
      @(negedge clock);
      g++;
    end
    chk({tag, "_drain_done"}, 32'(g < 1000), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_RDreturn", RDreturn, 32'd0);
    chk("rst_RDdest", 32'(RDdest), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_dest_zero), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // single request: cycle-exact timing relative to the accept edge
    send(4'd3, 24'h000120);
    for (int i = 1; i <= 13; i++) begin
      chk($sformatf("single_en_T%0d", i), 32'(mem_rd_en), 32'((i >= 2 && i <= 9) ? 1 : 0));
      chk($sformatf("single_dest_T%0d", i), 32'(RDdest), 32'((i >= 4 && i <= 11) ? 3 : 0));
      chk($sformatf("single_data_T%0d", i), RDreturn, (i >= 4 && i <= 11) ? 32'h120 + 32'(i - 4) : 32'h0);
      chk($sformatf("single_busy_T%0d", i), 32'(busy), 32'((i <= 10) ? 1 : 0));
      if (i == 2) chk("single_first_addr", 32'(mem_rd_addr), 32'h120);
      @(negedge clock);
    end
    drain("single");

    // word-order check with a non-zero offset
    send(4'd4, 24'h000125);
    drain("cwf");

    // two back-to-back requests: 16 contiguous return cycles, busy falls 2 after last read
    send(4'd2, 24'h000200);
    send(4'd5, 24'h000300);
    last_en = -1; busy_fall = -1; run = 0; max_run = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_rd_en) last_en = cyc;
      if (last_en >= 0 && !busy && busy_fall < 0) busy_fall = cyc;
      if (RDdest != 4'h0) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(negedge clock);
    end
    chk("b2b_contiguous_run", 32'(max_run), 32'd16);
    chk("b2b_busy_fall", 32'(busy_fall - last_en), 32'd2);
    drain("b2b");

    // fill the queue faster than bursts drain it
    n = words_seen;
    for (int i = 0; i < 24; i++) send(4'((i % 15) + 1), 24'h001000 + 24'(i * 8) + 24'd3);
    chk("fill_saw_stall", 32'(saw_stall), 32'd1);
    drain("fill");
    chk("fill_words", 32'(words_seen - n), 32'(24 * 8));

    // dest 0 between two valid requests
    chk("dz_err_before", 32'(err_dest_zero), 32'd0);
    send(4'd6, 24'h000400);
    send(4'd0, 24'h000500);
    send(4'd7, 24'h000600);
    drain("dz");
    chk("dz_err_set", 32'(err_dest_zero), 32'd1);
    chk("dz_no_burst", 32'(bad_line), 32'd0);
    repeat (5) @(negedge clock);
    chk("dz_err_sticky", 32'(err_dest_zero), 32'd1);

    // reset at word 4 of a burst with three more queued
    send(4'd1, 24'h000700);
    send(4'd2, 24'h000800);
    send(4'd3, 24'h000900);
    send(4'd4, 24'h000a00);
    n = 0;
    while (!(mem_rd_en && mem_rd_addr == 24'h000704) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("rstmid_reached_word4", 32'(n < 100), 32'd1);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("rstmid_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rstmid_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rstmid_RDreturn", RDreturn, 32'd0);
    chk("rstmid_RDdest", 32'(RDdest), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_err_clear", 32'(err_dest_zero), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    en_after_rst = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en || RDdest != 4'h0) en_after_rst = 1;
      @(negedge clock);
    end
    chk("rstmid_no_more_reads", 32'(en_after_rst), 32'd0);
    chk("rstmid_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
